delay_scheduler: RTL and testbench

- Shares one saturating delay timer among `NREQ` requesters.
- Each requester asks for a delay of `len` cycles.
- The scheduler grants the timer to exactly one requester, runs it to completion and pulses that requester's acknowledge.
- It sits between the game-logic FSMs and the shared timing resource, replacing per-FSM private counters.

---
 rtl/sched_pkg.sv | 13 +
 rtl/sched_timer.sv | 28 ++
 rtl/delay_scheduler.sv | 138 +++++++++++++
 tb/tb_delay_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the delay scheduler: FSM state encoding and default sizing.
package sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StAck  = 2'b10
  } sched_state_e;

  localparam int unsigned SCHED_NREQ = 4;
  localparam int unsigned SCHED_CW   = 3;

endpackage

// File: rtl/sched_timer.sv
// Saturating up-counter with synchronous clear/enable; done when count reaches limit-1.
module sched_timer #(
  parameter int unsigned CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] count_o,
  output logic          done_o
);

  logic [CW-1:0] count_q;

  assign done_o  = (count_q == limit_i - CW'(1));
  assign count_o = count_q;

  // Hold at limit-1 so the count never wraps while waiting for the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i && !done_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Shares one saturating delay timer among NREQ requesters (IDLE -> RUN -> ACK).
// Define DELAY_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module delay_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NREQ = SCHED_NREQ,
  parameter int unsigned CW   = SCHED_CW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*CW-1:0] len_i,
  input  logic               abort_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    ack_o,
  output logic               busy_o,
  output logic [CW-1:0]      count_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e    state_q;
  logic [NREQ-1:0] gnt_q, ack_q;
  logic [CW-1:0]   len_q;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [CW-1:0]   win_len;
  logic            tmr_clr, tmr_en, tmr_done;

`ifdef DELAY_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, win_q;

  // Scan from the farthest offset down so the nearest request at/after ptr wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      win_q <= '0;
    end else begin
      if ((state_q != StRun) && (state_q != StAck) && win_found) begin
        win_q <= win_idx;
      end
      if ((state_q == StAck) || ((state_q == StRun) && abort_i)) begin
        ptr_q <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
      end
    end
  end
`endif

  assign win_oh  = NREQ'(1) << win_idx;
  assign win_len = len_i[win_idx*CW +: CW];

  // Clearing on abort keeps the following IDLE cycle at count 0.
  assign tmr_en  = (state_q == StRun);
  assign tmr_clr = (state_q != StRun) || abort_i;

  sched_timer #(
    .CW(CW)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .limit_i(len_q),
    .count_o(count_o),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      len_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        StRun: begin
          if (abort_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
          end else if (tmr_done) begin
            state_q <= StAck;
            ack_q   <= gnt_q;
          end
        end
        StAck: begin
          state_q <= StIdle;
          gnt_q   <= '0;
        end
        default: begin
          if (win_found) begin
            len_q <= win_len;
            gnt_q <= win_oh;
            if (win_len == '0) begin
              state_q <= StAck;
              ack_q   <= win_oh;
            end else begin
              state_q <= StRun;
            end
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign busy_o = (state_q == StRun) || (state_q == StAck);

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed self-checking bench for delay_scheduler (NREQ=4, CW=3).
module tb_delay_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] len;
  logic        abort;
  logic [3:0]  gnt, ack;
  logic        busy;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  delay_scheduler #(
    .NREQ(4),
    .CW  (3)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .len_i  (len),
    .abort_i(abort),
    .gnt_o  (gnt),
    .ack_o  (ack),
    .busy_o (busy),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " gnt"}, 32'(gnt), 32'h0);
    check_eq({tag, " ack"}, 32'(ack), 32'h0);
    check_eq({tag, " busy"}, 32'(busy), 32'h0);
    check_eq({tag, " count"}, 32'(count), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    rst   = 1'b1;
    req   = 4'b1111;
    len   = '0;
    abort = 1'b0;

    // 1. Reset held two cycles, then first grant to requester 0 (len=0).
    tick(); check_idle("rst c1");
    tick(); check_idle("rst c2");
    rst = 1'b0;
    tick();
    check_eq("rst first gnt", 32'(gnt), 32'h1);
    check_eq("rst first ack", 32'(ack), 32'h1);
    req = 4'b0000;
    tick(); check_idle("rst after");

    // 2. Single delay: req[2], len=3.
    req = 4'b0100;
    len[6 +: 3] = 3'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("single gnt", 32'(gnt), 32'h4);
      check_eq("single count", 32'(count), 32'(k));
      check_eq("single ack early", 32'(ack), 32'h0);
    end
    tick();
    check_eq("single ack", 32'(ack), 32'h4);
    check_eq("single gnt@ack", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick(); check_idle("single done");

    // 4. Zero length: req[1], len=0.
    req = 4'b0010;
    len[3 +: 3] = 3'd0;
    tick();
    check_eq("zero gnt", 32'(gnt), 32'h2);
    check_eq("zero ack", 32'(ack), 32'h2);
    check_eq("zero count", 32'(count), 32'h0);
    req = 4'b0000;
    tick(); check_idle("zero done");

    // 5. Abort: req[3] len=5, req[0] arrives mid-run, abort at count=1.
    req = 4'b1000;
    len[9 +: 3] = 3'd5;
    len[0 +: 3] = 3'd1;
    tick();
    check_eq("abort gnt", 32'(gnt), 32'h8);
    req = 4'b1001;
    tick();
    check_eq("abort count1", 32'(count), 32'h1);
    abort = 1'b1;
    req   = 4'b0001;
    tick(); check_idle("abort idle");
    abort = 1'b0;
    tick();
    check_eq("abort next gnt", 32'(gnt), 32'h1);
    tick();
    check_eq("abort next ack", 32'(ack), 32'h1);
    req = 4'b0000;
    tick(); check_idle("abort done");

    // 6. Reset mid-run at count=2.
    req = 4'b0100;
    len[6 +: 3] = 3'd5;
    tick(); tick(); tick();
    check_eq("midrst count2", 32'(count), 32'h2);
    rst = 1'b1;
    tick(); check_idle("midrst c1");
    rst = 1'b0;
    req = 4'b0000;
    tick(); check_idle("midrst c2");

    // 3. Round-robin with all requesting, len=1 each.
    req = 4'b1111;
    len = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int j = 0; j < 5; j++) begin
`ifdef DELAY_SCHED_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (j % 4);
`endif
      tick();
      check_eq("rr gnt", 32'(gnt), 32'(exp_g));
      check_eq("rr count", 32'(count), 32'h0);
      tick();
      check_eq("rr ack", 32'(ack), 32'(exp_g));
      tick();
      check_eq("rr idle gnt", 32'(gnt), 32'h0);
      check_eq("rr idle busy", 32'(busy), 32'h0);
    end
    req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
